// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit PRBS path (x^5+x^3+1, period 31).
// Generator and checker both use lfsr_nxt so they always agree on the polynomial.
package lfsr_pkg;

   localparam int                LFSR_W    = 5;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   function automatic logic [LFSR_W-1:0] lfsr_nxt(input logic [LFSR_W-1:0] x);
      return {x[0] ^ x[2], x[4:1]};
   endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// PRBS self-check: acquires lock on the incoming LFSR stream, then free-runs a
// flywheel reference, counting mismatches and dropping lock after a run of misses.
//
//   state  | meaning
//   HUNT   | compare each sample with nxt(previous sample); LOCK_CNT good transitions lock
//   LOCKED | compare with flywheel reference; LOSS_CNT consecutive misses return to HUNT
module lfsr_seq_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [LFSR_W-1:0] in_data,
   input  logic              clear_cnt,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              wrap_pulse
);

   localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
   localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [LFSR_W-1:0] prev_q, prev_d;
   logic [LFSR_W-1:0] expected_q, expected_d;
   logic [3:0]        match_cnt_q, match_cnt_d;
   logic [3:0]        miss_cnt_q, miss_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              err_pulse_q, err_pulse_d;
   logic              wrap_pulse_q, wrap_pulse_d;
   logic              err_inc;

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      expected_d   = expected_q;
      match_cnt_d  = match_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      err_pulse_d  = 1'b0;
      wrap_pulse_d = 1'b0;
      err_inc      = 1'b0;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               prev_d = in_data;
               // nxt(0) == 0, so an all-zero stream would otherwise look valid
               if ((in_data == lfsr_nxt(prev_q)) && (in_data != '0)) begin
                  if (match_cnt_q + 4'd1 == LOCK_C) begin
                     state_d     = LOCKED;
                     expected_d  = lfsr_nxt(in_data);
                     miss_cnt_d  = '0;
                     match_cnt_d = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + 4'd1;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               expected_d = lfsr_nxt(expected_q);
               if (in_data != expected_q) begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  miss_cnt_d  = miss_cnt_q + 4'd1;
                  if (miss_cnt_q + 4'd1 == LOSS_C) begin
                     state_d     = HUNT;
                     match_cnt_d = '0;
                     prev_d      = in_data;
                  end
               end else begin
                  miss_cnt_d   = '0;
                  wrap_pulse_d = (in_data == LFSR_SEED);
               end
            end
            default: state_d = HUNT;
         endcase
      end

      err_cnt_d = err_cnt_q;
      if (clear_cnt) begin
         err_cnt_d = '0;
      end else if (err_inc && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= HUNT;
         prev_q       <= '0;
         expected_q   <= '0;
         match_cnt_q  <= '0;
         miss_cnt_q   <= '0;
         err_cnt_q    <= '0;
         err_pulse_q  <= 1'b0;
         wrap_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         expected_q   <= expected_d;
         match_cnt_q  <= match_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         err_cnt_q    <= err_cnt_d;
         err_pulse_q  <= err_pulse_d;
         wrap_pulse_q <= wrap_pulse_d;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign err_pulse  = err_pulse_q;
   assign err_cnt    = err_cnt_q;
   assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: default instance plus a narrow-counter
// instance (ERR_W=4, LOSS_CNT=15) for saturation and clear-priority cases.
module tb_lfsr_seq_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid = 1'b0, clr = 1'b0;
   logic [4:0]  data = '0;
   logic        locked, errp, wrap;
   logic [15:0] errc;

   logic        valid2 = 1'b0, clr2 = 1'b0;
   logic [4:0]  data2 = '0;
   logic        locked2, errp2, wrap2;
   logic [3:0]  errc2;

   int          n_chk = 0, n_pass = 0;
   logic [4:0]  cur;
   int          wraps, wrap_at, errs_seen, lock_seen;

   always #5 clk = ~clk;

   lfsr_seq_checker u_dut (
      .clk(clk), .reset(reset), .in_valid(valid), .in_data(data), .clear_cnt(clr),
      .locked(locked), .err_pulse(errp), .err_cnt(errc), .wrap_pulse(wrap)
   );

   lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(4)) u_dut_sat (
      .clk(clk), .reset(reset), .in_valid(valid2), .in_data(data2), .clear_cnt(clr2),
      .locked(locked2), .err_pulse(errp2), .err_cnt(errc2), .wrap_pulse(wrap2)
   );

   function automatic logic [4:0] tb_nxt(input logic [4:0] x);
      logic fb;
      fb = x[0] ^ x[2];
      return {fb, x[4:1]};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [4:0] d);
      valid = 1'b1; data = d; step(); valid = 1'b0;
   endtask

   task automatic idle(input logic [4:0] d);
      valid = 1'b0; data = d; step();
   endtask

   task automatic feed2(input logic [4:0] d);
      valid2 = 1'b1; data2 = d; step(); valid2 = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_locked", locked, 0);
      check("rst_err_cnt", errc, 0);
      check("rst_err_pulse", errp, 0);
      check("rst_wrap", wrap, 0);
      check("rst_sat_locked", locked2, 0);
      reset = 1'b1;

      // acquire lock from seed
      cur = 5'b00001;
      for (int i = 0; i < 5; i++) begin
         feed(cur); cur = tb_nxt(cur);
         if (i == 0) check("no_wrap_in_hunt", wrap, 0);
         if (i == 3) check("lock_not_yet", locked, 0);
      end
      check("lock_after_5", locked, 1);
      wraps = 0; wrap_at = -1; errs_seen = 0;
      for (int i = 5; i < 36; i++) begin
         feed(cur); cur = tb_nxt(cur);
         if (wrap) begin wraps++; wrap_at = i; end
         if (errp) errs_seen++;
      end
      check("wrap_count", wraps, 1);
      check("wrap_index", wrap_at, 31);
      check("clean_no_pulses", errs_seen, 0);
      check("clean_err_cnt", errc, 0);

      // single corrupted word, flywheel keeps going
      feed(cur ^ 5'b00010); cur = tb_nxt(cur);
      check("single_err_pulse", errp, 1);
      check("single_err_cnt", errc, 1);
      check("single_still_locked", locked, 1);
      feed(cur); cur = tb_nxt(cur);
      check("after_err_pulse_low", errp, 0);
      for (int i = 0; i < 3; i++) begin feed(cur); cur = tb_nxt(cur); end
      check("flywheel_err_cnt", errc, 1);
      check("flywheel_locked", locked, 1);

      clr = 1'b1; idle(5'h1F); clr = 1'b0;
      check("clear_alone_cnt", errc, 0);
      check("clear_keeps_lock", locked, 1);

      // three consecutive misses drop lock
      feed(cur ^ 5'h1F); cur = tb_nxt(cur);
      check("loss1_locked", locked, 1);
      check("loss1_cnt", errc, 1);
      feed(cur ^ 5'h1F); cur = tb_nxt(cur);
      check("loss2_locked", locked, 1);
      feed(cur ^ 5'h1F); cur = tb_nxt(cur);
      check("loss3_locked", locked, 0);
      check("loss3_cnt", errc, 3);
      check("loss3_pulse", errp, 1);
      for (int i = 0; i < 5; i++) begin
         feed(cur); cur = tb_nxt(cur);
         if (i == 3) check("relock_not_yet", locked, 0);
      end
      check("relock", locked, 1);
      check("relock_cnt_held", errc, 3);

      // asynchronous reset while locked
      #2 reset = 1'b0;
      #1;
      check("async_rst_locked", locked, 0);
      check("async_rst_cnt", errc, 0);
      #3 reset = 1'b1;

      // gapped valid, garbage data on idle cycles
      cur = 5'b00001; errs_seen = 0;
      for (int i = 0; i < 5; i++) begin
         feed(cur); cur = tb_nxt(cur);
         idle(5'h1F);
         if (errp || wrap) errs_seen++;
         idle(5'h00);
         if (errp || wrap) errs_seen++;
         if (i == 3) check("gap_lock_not_yet", locked, 0);
      end
      check("gap_locked", locked, 1);
      for (int i = 0; i < 6; i++) begin
         feed(cur); cur = tb_nxt(cur);
         if (errp) errs_seen++;
         idle(5'h15);
         if (errp || wrap) errs_seen++;
      end
      check("gap_no_errors", errs_seen, 0);
      check("gap_err_cnt", errc, 0);
      check("gap_still_locked", locked, 1);

      // all-zero input never locks
      reset = 1'b0; #2 reset = 1'b1;
      lock_seen = 0;
      for (int i = 0; i < 40; i++) begin
         feed(5'h00);
         if (locked) lock_seen++;
      end
      check("zeros_never_lock", lock_seen, 0);
      check("zeros_err_cnt", errc, 0);

      // narrow counter instance: saturation, clear priority, LOSS_CNT=15
      cur = 5'b00001;
      for (int i = 0; i < 5; i++) begin feed2(cur); cur = tb_nxt(cur); end
      check("sat_locked", locked2, 1);
      for (int i = 0; i < 10; i++) begin feed2(cur ^ 5'h1F); cur = tb_nxt(cur); end
      check("sat_cnt_10", errc2, 10);
      feed2(cur); cur = tb_nxt(cur);
      for (int i = 0; i < 10; i++) begin
         feed2(cur ^ 5'h1F); cur = tb_nxt(cur);
         if (i == 4) check("sat_cnt_15", errc2, 15);
      end
      check("sat_cnt_held", errc2, 15);
      check("sat_still_locked", locked2, 1);
      clr2 = 1'b1; feed2(cur ^ 5'h1F); cur = tb_nxt(cur); clr2 = 1'b0;
      check("clr_wins_cnt", errc2, 0);
      check("clr_wins_pulse", errp2, 1);
      feed2(cur ^ 5'h1F); cur = tb_nxt(cur);
      check("after_clr_cnt", errc2, 1);
      feed2(cur ^ 5'h1F); cur = tb_nxt(cur);
      feed2(cur ^ 5'h1F); cur = tb_nxt(cur);
      check("miss14_locked", locked2, 1);
      feed2(cur ^ 5'h1F); cur = tb_nxt(cur);
      check("miss15_unlocked", locked2, 0);
      check("miss15_cnt", errc2, 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 5-bit Galois LFSR output. Checks that the incoming 5-bit word stream follows the maximal-length sequence (x^5+x^3+1, period 31).
- Acquires lock, then runs a flywheel reference. Counts mismatches and flags loss of lock.
- Used as the built-in self-check on the PRBS path.

Parameters:
- LOCK_CNT, 4, consecutive correct transitions required to declare lock (range 1..15)
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (range 1..15)
- ERR_W, 16, width of the saturating error counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is a new LFSR sample this cycle
- in_data  input  5  LFSR output word (q of the upstream LFSR)
- clear_cnt  input  1  synchronous clear of err_cnt
- locked  output  1  checker is in LOCKED state
- err_pulse  output  1  one-cycle pulse per mismatching sample while LOCKED
- err_cnt  output  ERR_W  saturating mismatch count
- wrap_pulse  output  1  one-cycle pulse when a matched sample equals 5'b00001 while LOCKED

Behaviour:
- Prediction function: nxt(x) = {x[0]^x[2], x[4:1]}.
  - Example sequence: 00001 -> 10000 -> 01000 -> 00100 -> 10010 -> 01001 -> 10100 -> ...
- Reset (reset low, asynchronous):
  - state=HUNT, locked=0, err_pulse=0, wrap_pulse=0, err_cnt=0.
  - prev=0, match_cnt=0, miss_cnt=0.
- Samples are evaluated only when in_valid=1. With in_valid=0, all state holds and pulses are 0.
- HUNT:
  - Each valid sample is compared with nxt(prev), then prev<=in_data.
  - Match with in_data!=0: match_cnt++.
  - Mismatch or in_data==0: match_cnt<=0.
  - The first sample after reset always mismatches, because prev=0 and nxt(0)=0 is illegal.
  - When the matching sample brings match_cnt to LOCK_CNT: next state LOCKED, expected<=nxt(in_data), miss_cnt<=0.
  - No errors are counted in HUNT.
- LOCKED:
  - Each valid sample is compared with expected. expected<=nxt(expected) regardless of outcome (flywheel; never reloaded from input).
  - Mismatch: err_pulse=1 the next cycle, err_cnt++ (saturates at all-ones, no wrap), miss_cnt++.
  - Match: miss_cnt<=0. wrap_pulse=1 the next cycle if in_data==5'b00001.
  - When miss_cnt reaches LOSS_CNT: next state HUNT, match_cnt<=0, prev<=in_data.
  - The losing sample's err_pulse and count still occur.
- Registered outputs. Latency is 1 cycle from the valid sample edge to err_pulse, wrap_pulse, err_cnt update and the locked change.
- clear_cnt:
  - Sets err_cnt to 0 next cycle.
  - If clear_cnt coincides with an error increment, clear wins (err_cnt=0). err_pulse still fires.
  - clear_cnt does not affect state.
- An all-zero input in LOCKED is an ordinary mismatch.
- expected is never 0 once LOCKED is entered correctly.
- Reset asserted mid-operation returns everything to reset values immediately. No lock is retained.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W=5
  - LFSR_SEED=5'b00001
  - state enum {HUNT, LOCKED}
  - function lfsr_nxt(x), which is shared with the LFSR generator so both use one polynomial definition
- No sub-module needed; the checker is one FSM plus counters.
  - Optional sub-module sat_counter (ERR_W, inc, clr) for err_cnt.

Test Plan:
- Drive the LFSR sequence from seed 00001 with in_valid=1 every cycle -> locked=1 one cycle after the 5th sample (4 matching transitions); err_cnt stays 0; wrap_pulse every 31 samples.
- Once locked, replace one sample (e.g. 01001 -> 01011) -> single err_pulse; err_cnt=1; locked stays 1; the next correct samples match (flywheel not disturbed).
- Once locked, inject 3 consecutive wrong words -> err_cnt=3, locked=0 one cycle after the 3rd; feeding the correct stream again re-locks after 4 further matches.
- Gap in_valid (valid 1,0,0,1,...) on the correct stream -> lock acquired, no errors, state frozen on idle cycles.
- ERR_W=4, LOSS_CNT=15, continuous errors -> err_cnt saturates at 15; clear_cnt coincident with an error -> err_cnt=0 while err_pulse=1.
- Constant 00000 input -> never locks, err_cnt=0. Assert reset while locked -> locked=0 and err_cnt=0 asynchronously.
